// File: rtl/stream_buffer_fifo_gen.sv
// Parametrised first-word-fall-through stream FIFO with occupancy flags,
// selectable overflow policy, sticky error flags and a saturating drop counter.
module stream_buffer_fifo_gen #(
    parameter int DATA_WIDTH  = 40,
    parameter int ADDR_WIDTH  = 3,
    parameter int AF_LEVEL    = 6,
    parameter int AE_LEVEL    = 1,
    parameter int DROP_OLDEST = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [15:0]           drop_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic                DROP_C  = (DROP_OLDEST != 0);

    generate
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_levels
            $error("stream_buffer_fifo_gen: AF_LEVEL/AE_LEVEL out of range for DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  full_push;
    logic                  wr_ok;
    logic                  rd_adv;

    // Flags decode straight from the registered pointers; reset values fall out of ptr=0.
    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign data_out     = mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_comb begin
        full_push = wr_en && !rd_en && full;
        wr_ok     = wr_en && (!full || rd_en || DROP_C);
        // Drop-oldest mode makes room by retiring the head word alongside the write.
        rd_adv    = (rd_en && !empty) || (full_push && DROP_C);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (full_push) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !clear) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_stream_buffer_fifo_gen.sv
// Drives a reject-mode and a drop-oldest-mode FIFO with identical stimulus and
// compares each against a queue-style reference model every cycle.
module tb_stream_buffer_fifo_gen;

    localparam int DW    = 40;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] data_out [2];
    logic          full [2];
    logic          empty [2];
    logic          almost_full [2];
    logic          almost_empty [2];
    logic [AW:0]   count [2];
    logic          overflow [2];
    logic          underflow [2];
    logic [15:0]   drop_count [2];

    int checks;
    int failures;

    // Reference model: circular list of words with explicit head and size.
    logic [DW-1:0] mq [2][DEPTH];
    int            mhead [2];
    int            msize [2];
    logic          movf [2];
    logic          mudf [2];
    int            mdrop [2];

    stream_buffer_fifo_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(6), .AE_LEVEL(1), .DROP_OLDEST(0)) dut_rej (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out[0]), .full(full[0]), .empty(empty[0]), .almost_full(almost_full[0]),
        .almost_empty(almost_empty[0]), .count(count[0]), .overflow(overflow[0]),
        .underflow(underflow[0]), .drop_count(drop_count[0])
    );

    stream_buffer_fifo_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(6), .AE_LEVEL(1), .DROP_OLDEST(1)) dut_drop (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out[1]), .full(full[1]), .empty(empty[1]), .almost_full(almost_full[1]),
        .almost_empty(almost_empty[1]), .count(count[1]), .overflow(overflow[1]),
        .underflow(underflow[1]), .drop_count(drop_count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mhead[m] = 0;
            msize[m] = 0;
            movf[m]  = 1'b0;
            mudf[m]  = 1'b0;
            mdrop[m] = 0;
        end
    endtask

    task automatic model_push(input int m, input logic [DW-1:0] d);
        mq[m][(mhead[m] + msize[m]) % DEPTH] = d;
        msize[m]++;
    endtask

    task automatic model_pop(input int m);
        mhead[m] = (mhead[m] + 1) % DEPTH;
        msize[m]--;
    endtask

    task automatic model_step(input int m);
        if (clear) begin
            mhead[m] = 0;
            msize[m] = 0;
            movf[m]  = 1'b0;
            mudf[m]  = 1'b0;
            mdrop[m] = 0;
        end else if (wr_en && rd_en && msize[m] == 0) begin
            model_push(m, data_in);
            mudf[m] = 1'b1;
        end else if (wr_en && !rd_en && msize[m] == DEPTH) begin
            movf[m] = 1'b1;
            if (mdrop[m] < 65535) mdrop[m]++;
            if (m == 1) begin
                model_pop(m);
                model_push(m, data_in);
            end
        end else begin
            if (rd_en && msize[m] == 0) mudf[m] = 1'b1;
            if (rd_en && msize[m] > 0) model_pop(m);
            if (wr_en) model_push(m, data_in);
        end
    endtask

    task automatic check_dut(input int m);
        string nm;
        nm = (m == 0) ? "rej" : "drop";
        check({nm, ".count"}, 64'(count[m]), 64'(msize[m]));
        check({nm, ".full"}, 64'(full[m]), 64'(msize[m] == DEPTH));
        check({nm, ".empty"}, 64'(empty[m]), 64'(msize[m] == 0));
        check({nm, ".almost_full"}, 64'(almost_full[m]), 64'(msize[m] >= 6));
        check({nm, ".almost_empty"}, 64'(almost_empty[m]), 64'(msize[m] <= 1));
        check({nm, ".overflow"}, 64'(overflow[m]), 64'(movf[m]));
        check({nm, ".underflow"}, 64'(underflow[m]), 64'(mudf[m]));
        check({nm, ".drop_count"}, 64'(drop_count[m]), 64'(mdrop[m]));
        if (msize[m] > 0) begin
            check({nm, ".data_out"}, 64'(data_out[m]), 64'(mq[m][mhead[m]]));
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic drive(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        clear   = c;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        logic [DW-1:0] rnd;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        clear    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_dut(0);
        check_dut(1);
        #2 reset = 1'b1;
        @(negedge clk);

        // Fill and drain
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, DW'(i), 1'b0);
        check("fill.full", 64'(full[0]), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            check("drain.order", 64'(data_out[0]), 64'(i));
            drive(1'b0, 1'b1, '0, 1'b0);
        end
        check("drain.empty", 64'(empty[0]), 64'd1);

        // Overflow: reject keeps 1..8, drop-oldest keeps 3..10
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, DW'(i), 1'b0);
        drive(1'b1, 1'b0, DW'('h09), 1'b0);
        drive(1'b1, 1'b0, DW'('h0A), 1'b0);
        check("ovf.rej_drops", 64'(drop_count[0]), 64'd2);
        check("ovf.drop_drops", 64'(drop_count[1]), 64'd2);
        check("ovf.drop_head", 64'(data_out[1]), 64'h03);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, '0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1);

        // Empty with simultaneous read and write
        drive(1'b1, 1'b1, DW'('h55), 1'b0);
        check("empty_rw.data", 64'(data_out[0]), 64'h55);
        check("empty_rw.underflow", 64'(underflow[0]), 64'd1);
        drive(1'b0, 1'b0, '0, 1'b1);

        // Full with simultaneous read and write
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, DW'(i + 16), 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, DW'(i + 32), 1'b0);
        check("full_rw.overflow", 64'(overflow[1]), 64'd0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, '0, 1'b0);

        // Sustained throughput at occupancy 3
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, DW'(i), 1'b0);
        for (int i = 3; i < 103; i++) begin
            check("thru.delay3", 64'(data_out[0]), 64'(i - 3));
            drive(1'b1, 1'b1, DW'(i), 1'b0);
        end

        // Async reset at count 5
        drive(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'(i + 64), 1'b0);
        async_reset_pulse();

        // Clear with a coincident write, after provoking overflow
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, DW'(i + 80), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '0, 1'b0);
        drive(1'b1, 1'b0, DW'('hBEEF), 1'b1);
        check("clear.count", 64'(count[0]), 64'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rnd = {8'($urandom_range(255)), 32'($urandom)};
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), rnd, $urandom_range(99) == 0);
            if ($urandom_range(499) == 0) async_reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
